// File: rtl/up_dn_counter_lim.sv
// up_dn_counter_lim: parametrised up/down counter with a per-cycle step,
// programmable lower/upper limits and run-time saturate/wrap selection.
// Provides sticky overflow/underflow flags, a one-cycle wrap pulse (tc)
// and a combinational limit-configuration error flag.
module up_dn_counter_lim #(
  parameter int               WIDTH   = 5,
  parameter int               STEP_W  = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WIDTH-1:0]  in_val,
  input  logic              up,
  input  logic              down,
  input  logic [STEP_W-1:0] step,
  input  logic              wrap_en,
  input  logic [WIDTH-1:0]  min_lim,
  input  logic [WIDTH-1:0]  max_lim,
  input  logic              clr_flags,
  output logic [WIDTH-1:0]  counter,
  output logic              high,
  output logic              low,
  output logic              ovf,
  output logic              unf,
  output logic              tc,
  output logic              cfg_err
);

  // Clamp a value into [lo, hi]; callers guarantee lo <= hi.
  function automatic logic [WIDTH-1:0] clamp_val(
    input logic [WIDTH-1:0] v,
    input logic [WIDTH-1:0] lo,
    input logic [WIDTH-1:0] hi
  );
    logic [WIDTH-1:0] r;
    if (v < lo) begin
      r = lo;
    end else if (v > hi) begin
      r = hi;
    end else begin
      r = v;
    end
    return r;
  endfunction

  logic [WIDTH-1:0] counter_r;
  logic             ovf_r;
  logic             unf_r;
  logic             tc_r;

  // One extra bit so borrow/carry out of the counter range stay visible.
  logic [WIDTH:0]   cnt_ext_s;
  logic [WIDTH:0]   step_ext_s;
  logic [WIDTH:0]   dn_sum_s;
  logic [WIDTH:0]   up_sum_s;
  logic [WIDTH:0]   max_ext_s;
  logic             step_nz_s;
  logic             unf_evt_s;
  logic             ovf_evt_s;
  logic             cfg_err_s;
  logic [WIDTH-1:0] load_val_s;

  logic [WIDTH-1:0] cnt_nxt_s;
  logic             ovf_nxt_s;
  logic             unf_nxt_s;
  logic             tc_nxt_s;

  assign cnt_ext_s  = {1'b0, counter_r};
  assign step_ext_s = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
  assign max_ext_s  = {1'b0, max_lim};
  assign dn_sum_s   = cnt_ext_s - step_ext_s;
  assign up_sum_s   = cnt_ext_s + step_ext_s;
  assign step_nz_s  = (step != {STEP_W{1'b0}});

  // A zero step never produces an event, even when sitting at or beyond a limit.
  assign unf_evt_s  = step_nz_s & (dn_sum_s[WIDTH] | (dn_sum_s[WIDTH-1:0] < min_lim));
  assign ovf_evt_s  = step_nz_s & (up_sum_s > max_ext_s);

  assign cfg_err_s  = (min_lim > max_lim);
  assign load_val_s = clamp_val(in_val, min_lim, max_lim);

  // Next-state selection: cfg_err hold > load > down > up; clr_flags applies
  // independently and loses to a coincident new event.
  always_comb begin
    cnt_nxt_s = counter_r;
    ovf_nxt_s = clr_flags ? 1'b0 : ovf_r;
    unf_nxt_s = clr_flags ? 1'b0 : unf_r;
    tc_nxt_s  = 1'b0;
    if (cfg_err_s) begin
      cnt_nxt_s = counter_r;
    end else if (load) begin
      cnt_nxt_s = load_val_s;
    end else if (down) begin
      if (unf_evt_s) begin
        unf_nxt_s = 1'b1;
        if (wrap_en) begin
          cnt_nxt_s = max_lim;
          tc_nxt_s  = 1'b1;
        end else begin
          cnt_nxt_s = min_lim;
        end
      end else begin
        cnt_nxt_s = dn_sum_s[WIDTH-1:0];
      end
    end else if (up) begin
      if (ovf_evt_s) begin
        ovf_nxt_s = 1'b1;
        if (wrap_en) begin
          cnt_nxt_s = min_lim;
          tc_nxt_s  = 1'b1;
        end else begin
          cnt_nxt_s = max_lim;
        end
      end else begin
        cnt_nxt_s = up_sum_s[WIDTH-1:0];
      end
    end else begin
      cnt_nxt_s = counter_r;
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      counter_r <= RST_VAL;
      ovf_r     <= 1'b0;
      unf_r     <= 1'b0;
      tc_r      <= 1'b0;
    end else begin
      counter_r <= cnt_nxt_s;
      ovf_r     <= ovf_nxt_s;
      unf_r     <= unf_nxt_s;
      tc_r      <= tc_nxt_s;
    end
  end

  assign counter = counter_r;
  assign ovf     = ovf_r;
  assign unf     = unf_r;
  assign tc      = tc_r;
  assign high    = (counter_r >= max_lim);
  assign low     = (counter_r <= min_lim);
  assign cfg_err = cfg_err_s;

endmodule

// File: tb/tb_up_dn_counter_lim.sv
// Directed self-checking bench for up_dn_counter_lim (WIDTH=5, STEP_W=3, RST_VAL=3).
module tb_up_dn_counter_lim;

  logic       clk;
  logic       rst;
  logic       load;
  logic [4:0] in_val;
  logic       up;
  logic       down;
  logic [2:0] step;
  logic       wrap_en;
  logic [4:0] min_lim;
  logic [4:0] max_lim;
  logic       clr_flags;
  logic [4:0] counter;
  logic       high;
  logic       low;
  logic       ovf;
  logic       unf;
  logic       tc;
  logic       cfg_err;

  int errors = 0;
  int checks = 0;

  up_dn_counter_lim #(
    .WIDTH  (5),
    .STEP_W (3),
    .RST_VAL(5'd3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .in_val   (in_val),
    .up       (up),
    .down     (down),
    .step     (step),
    .wrap_en  (wrap_en),
    .min_lim  (min_lim),
    .max_lim  (max_lim),
    .clr_flags(clr_flags),
    .counter  (counter),
    .high     (high),
    .low      (low),
    .ovf      (ovf),
    .unf      (unf),
    .tc       (tc),
    .cfg_err  (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    load = 1'b0; up = 1'b0; down = 1'b0; clr_flags = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; up = 1'b1; step = 3'd1; min_lim = 5'd0; max_lim = 5'd31;
    tick();
    checks++; if (counter !== 5'd3) begin errors++; $display("FAIL reset_cnt got %0d exp 3", counter); end
    checks++; if ({ovf, unf, tc} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {ovf, unf, tc}); end
    tick();
    checks++; if (counter !== 5'd3) begin errors++; $display("FAIL reset_hold got %0d exp 3", counter); end
    rst = 1'b0;
    tick();
    checks++; if (counter !== 5'd4) begin errors++; $display("FAIL reset_release got %0d exp 4", counter); end
    checks++; if ({high, low, cfg_err} !== 3'b000) begin errors++; $display("FAIL reset_comb got %b exp 000", {high, low, cfg_err}); end
    idle();
  endtask

  task automatic test_saturate_up();
    min_lim = 5'd2; max_lim = 5'd20; wrap_en = 1'b0;
    load = 1'b1; in_val = 5'd18;
    tick();
    checks++; if (counter !== 5'd18) begin errors++; $display("FAIL sat_load got %0d exp 18", counter); end
    load = 1'b0; up = 1'b1; step = 3'd3;
    tick();
    checks++; if ({counter, ovf, tc} !== {5'd20, 1'b1, 1'b0}) begin errors++; $display("FAIL sat_up1 got cnt=%0d ovf=%b tc=%b exp 20 1 0", counter, ovf, tc); end
    tick();
    checks++; if ({counter, ovf, tc} !== {5'd20, 1'b1, 1'b0}) begin errors++; $display("FAIL sat_up2 got cnt=%0d ovf=%b tc=%b exp 20 1 0", counter, ovf, tc); end
    checks++; if (high !== 1'b1) begin errors++; $display("FAIL sat_high got %b exp 1", high); end
    idle();
  endtask

  task automatic test_wrap();
    clr_flags = 1'b1;
    tick();
    checks++; if ({ovf, unf} !== 2'b00) begin errors++; $display("FAIL wrap_clr got %b exp 00", {ovf, unf}); end
    idle(); wrap_en = 1'b1; load = 1'b1; in_val = 5'd4;
    tick();
    load = 1'b0; down = 1'b1; step = 3'd3;
    tick();
    checks++; if ({counter, unf, tc} !== {5'd20, 1'b1, 1'b1}) begin errors++; $display("FAIL wrap_dn got cnt=%0d unf=%b tc=%b exp 20 1 1", counter, unf, tc); end
    down = 1'b0;
    tick();
    checks++; if ({counter, unf, tc} !== {5'd20, 1'b1, 1'b0}) begin errors++; $display("FAIL wrap_tc_pulse got cnt=%0d unf=%b tc=%b exp 20 1 0", counter, unf, tc); end
    up = 1'b1;
    tick();
    checks++; if ({counter, ovf, tc} !== {5'd2, 1'b1, 1'b1}) begin errors++; $display("FAIL wrap_up got cnt=%0d ovf=%b tc=%b exp 2 1 1", counter, ovf, tc); end
    idle(); wrap_en = 1'b0;
  endtask

  task automatic test_priority();
    clr_flags = 1'b1; load = 1'b1; in_val = 5'd10;
    tick();
    idle(); up = 1'b1; down = 1'b1; step = 3'd1;
    tick();
    checks++; if (counter !== 5'd9) begin errors++; $display("FAIL prio_dn_over_up got %0d exp 9", counter); end
    load = 1'b1; in_val = 5'd31;
    tick();
    checks++; if ({counter, ovf, unf, tc} !== {5'd20, 3'b000}) begin errors++; $display("FAIL prio_load_clamp_hi got cnt=%0d flags=%b exp 20 000", counter, {ovf, unf, tc}); end
    in_val = 5'd0;
    tick();
    checks++; if ({counter, ovf, unf, tc} !== {5'd2, 3'b000}) begin errors++; $display("FAIL prio_load_clamp_lo got cnt=%0d flags=%b exp 2 000", counter, {ovf, unf, tc}); end
    idle();
  endtask

  task automatic test_flags();
    down = 1'b1; step = 3'd1;
    tick();
    checks++; if ({counter, unf, tc} !== {5'd2, 1'b1, 1'b0}) begin errors++; $display("FAIL flag_unf_set got cnt=%0d unf=%b tc=%b exp 2 1 0", counter, unf, tc); end
    down = 1'b0; clr_flags = 1'b1;
    tick();
    checks++; if (unf !== 1'b0) begin errors++; $display("FAIL flag_clr got %b exp 0", unf); end
    down = 1'b1;
    tick();
    checks++; if ({counter, unf} !== {5'd2, 1'b1}) begin errors++; $display("FAIL flag_clr_vs_evt got cnt=%0d unf=%b exp 2 1", counter, unf); end
    idle();
  endtask

  task automatic test_cfg_err();
    min_lim = 5'd15; max_lim = 5'd5; load = 1'b1; in_val = 5'd10; up = 1'b1; step = 3'd1;
    #1;
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_err_flag got %b exp 1", cfg_err); end
    tick();
    checks++; if ({counter, ovf, unf, tc} !== {5'd2, 3'b010}) begin errors++; $display("FAIL cfg_err_hold got cnt=%0d flags=%b exp 2 010", counter, {ovf, unf, tc}); end
    load = 1'b0; up = 1'b0; clr_flags = 1'b1;
    tick();
    checks++; if (unf !== 1'b0) begin errors++; $display("FAIL cfg_err_clr got %b exp 0", unf); end
    idle(); min_lim = 5'd2; max_lim = 5'd20; down = 1'b1; step = 3'd0;
    tick();
    checks++; if ({counter, ovf, unf, tc, low, cfg_err} !== {5'd2, 5'b00010}) begin errors++; $display("FAIL step0_at_min got cnt=%0d ovf/unf/tc/low/cfg=%b exp 2 00010", counter, {ovf, unf, tc, low, cfg_err}); end
    idle();
  endtask

  task automatic test_boundaries();
    max_lim = 5'd2;
    #1;
    checks++; if ({high, low} !== 2'b11) begin errors++; $display("FAIL min_eq_max_hl got %b exp 11", {high, low}); end
    max_lim = 5'd20; load = 1'b1; in_val = 5'd20;
    tick();
    idle(); max_lim = 5'd10; up = 1'b1; step = 3'd1;
    tick();
    checks++; if ({counter, ovf} !== {5'd10, 1'b1}) begin errors++; $display("FAIL above_max_up got cnt=%0d ovf=%b exp 10 1", counter, ovf); end
    idle(); clr_flags = 1'b1; min_lim = 5'd12; max_lim = 5'd20;
    tick();
    idle(); up = 1'b1;
    tick();
    checks++; if ({counter, ovf, low} !== {5'd11, 1'b0, 1'b1}) begin errors++; $display("FAIL below_min_up got cnt=%0d ovf=%b low=%b exp 11 0 1", counter, ovf, low); end
    idle(); down = 1'b1;
    tick();
    checks++; if ({counter, unf} !== {5'd12, 1'b1}) begin errors++; $display("FAIL below_min_dn got cnt=%0d unf=%b exp 12 1", counter, unf); end
    idle(); min_lim = 5'd0; max_lim = 5'd31; wrap_en = 1'b1; load = 1'b1; in_val = 5'd1;
    tick();
    idle(); down = 1'b1; step = 3'd3;
    tick();
    checks++; if ({counter, tc} !== {5'd31, 1'b1}) begin errors++; $display("FAIL borrow_wrap got cnt=%0d tc=%b exp 31 1", counter, tc); end
    idle(); load = 1'b1; in_val = 5'd30;
    tick();
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL load_no_tc got %b exp 0", tc); end
    idle(); clr_flags = 1'b1; up = 1'b1;
    tick();
    checks++; if ({counter, ovf, tc} !== {5'd0, 1'b1, 1'b1}) begin errors++; $display("FAIL carry_wrap got cnt=%0d ovf=%b tc=%b exp 0 1 1", counter, ovf, tc); end
    idle(); wrap_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    load = 1'b1; in_val = 5'd5;
    tick();
    idle(); up = 1'b1; step = 3'd2;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (counter !== 5'(7 + 2 * i)) begin errors++; $display("FAIL b2b_up%0d got %0d exp %0d", i, counter, 7 + 2 * i); end
    end
    idle(); down = 1'b1; step = 3'd7;
    tick();
    checks++; if (counter !== 5'd4) begin errors++; $display("FAIL b2b_dn7 got %0d exp 4", counter); end
    idle();
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; in_val = 5'd0; up = 1'b0; down = 1'b0; step = 3'd0;
    wrap_en = 1'b0; min_lim = 5'd0; max_lim = 5'd31; clr_flags = 1'b0;
    #2;
    test_reset();
    test_saturate_up();
    test_wrap();
    test_priority();
    test_flags();
    test_cfg_err();
    test_boundaries();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/up_dn_counter_lim.md
# up_dn_counter_lim

Parametrised up/down counter: the successor to the team's 5-bit load/up/down counter, with generic width, a per-cycle step size and programmable lower/upper limits. Each boundary crossing either saturates or wraps, selected at run time. Sticky overflow/underflow flags, a terminal-count pulse and a limit-configuration error flag are provided. The block sits in the control datapath as a bounded event/position counter feeding threshold logic.

## Interface
- WIDTH, 5, counter and limit width (>= 2)
- STEP_W, 3, width of step input (1..WIDTH)
- RST_VAL, 0, counter value after reset (WIDTH bits)

- clk  in  1  rising-edge clock; the only clock
- rst  in  1  synchronous, active-high reset
- load  in  1  load request
- in_val  in  WIDTH  load value
- up  in  1  count-up request
- down  in  1  count-down request
- step  in  STEP_W  increment/decrement magnitude, unsigned
- wrap_en  in  1  0 = saturate at limits, 1 = wrap to opposite limit
- min_lim  in  WIDTH  lower limit, unsigned, sampled every cycle
- max_lim  in  WIDTH  upper limit, unsigned, sampled every cycle
- clr_flags  in  1  clears ovf/unf
- counter  out  WIDTH  registered count
- high  out  1  combinational: counter >= max_lim
- low  out  1  combinational: counter <= min_lim
- ovf  out  1  registered sticky overflow
- unf  out  1  registered sticky underflow
- tc  out  1  registered one-cycle pulse on every wrap event
- cfg_err  out  1  combinational: min_lim > max_lim

## Operation
- Reset: counter = RST_VAL, ovf = unf = tc = 0. rst overrides every other input.
- Priority per cycle: rst > cfg_err hold > load > down > up. Down wins over simultaneous up.
- cfg_err = 1: counter holds, load/up/down are ignored, no flag or tc changes. clr_flags still works.
- Load: counter = in_val clamped to [min_lim, max_lim]. No flags, no tc.
- Arithmetic uses unsigned WIDTH+1 bits with step zero-extended.
  - Down: d = counter - step. Borrow or d < min_lim marks an underflow event.
  - Up: u = counter + step. u > max_lim, including carry, marks an overflow event.
- No event: counter = d or u.
- Underflow event: unf set. Counter becomes min_lim (wrap_en = 0) or max_lim (wrap_en = 1).
- Overflow event: ovf set. Counter becomes max_lim (wrap_en = 0) or min_lim (wrap_en = 1).
- tc = 1 for exactly the cycle after a wrap event, otherwise 0. Saturation never pulses tc.
- step = 0 with up or down: counter unchanged, no event, even at a limit.
- Down while already at min_lim with step > 0 is an underflow event: hold in saturate mode, wrap in wrap mode. Up at max_lim behaves symmetrically.
- Counter above max_lim after a limit change: next up is an overflow event. Next down is judged against min_lim only.
- Counter below min_lim after a limit change: mirror of the previous rule.
- clr_flags clears ovf and unf. A new event in the same cycle wins: the flag ends set.
- high and low may both be 1 when min_lim == max_lim == counter.

## Timing
- All state updates on the rising edge of clk. Load, count and reset latency is 1 cycle.
- ovf, unf and tc update on the same edge as the counter change that caused them.
- high, low and cfg_err are combinational from the current counter and limits, with zero latency.
- Request inputs are level-sensitive: up held for N cycles performs N steps.

## Test plan
- Reset, WIDTH = 5, RST_VAL = 3: assert rst with up = 1 -> counter = 3, ovf = unf = tc = 0. Deassert -> counter 4 on the next edge.
- Saturate up: min = 2, max = 20, load 18, step = 3, up for 2 cycles -> counter 20 with ovf = 1, then stays 20. tc never pulses. high = 1.
- Wrap down: wrap_en = 1, min = 2, max = 20, load 4, step = 3, down -> 1 is below min, so counter = 20, unf = 1, tc = 1 for one cycle.
- Priority: up = down = 1, step = 1, counter 10 -> 9. load = 1 with in_val = 31, max = 20 -> counter 20 (clamped), no flags.
- Flags: unf = 1, assert clr_flags alone -> unf = 0. clr_flags with a coincident underflow event -> unf = 1.
- Config error: min = 15, max = 5, load = 1, up = 1 -> cfg_err = 1, counter unchanged. step = 0 with down at min_lim -> no change, no flags.
